// File: rtl/rom_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_arbiter_if : requester-side ROM read request/response bundle |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface rom_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output valid,
    output addr,
    input  ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  valid,
    input  addr,
    output ready,
    output rsp_valid,
    output rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_arbiter : two-port round-robin arbiter for a sync-read ROM   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module rom_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  wire                   i_clk,
  input  wire                   i_rst_n,
  rom_arbiter_if.slave          req0,
  rom_arbiter_if.slave          req1,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  wire  [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_idle
);

  localparam logic c_ID_REQ0 = 1'b0;
  localparam logic c_ID_REQ1 = 1'b1;

  // Priority pointer: names the requester that wins when both are valid.
  logic                  r_ptr;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_s1_vld;
  logic                  r_s1_id;
  logic                  r_s2_vld;
  logic                  r_s2_id;
  logic                  r_rsp0_vld;
  logic                  r_rsp1_vld;
  logic [DATA_WIDTH-1:0] r_rsp0_data;
  logic [DATA_WIDTH-1:0] r_rsp1_data;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr;

  always_comb begin
    w_grant0 = req0.valid & (~req1.valid | (r_ptr == c_ID_REQ0));
    w_grant1 = req1.valid & (~req0.valid | (r_ptr == c_ID_REQ1));
    w_accept = w_grant0 | w_grant1;
    w_addr   = w_grant1 ? req1.addr : req0.addr;
  end

  assign req0.ready = w_grant0;
  assign req1.ready = w_grant1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= c_ID_REQ0;
      r_rom_addr <= '0;
    end else if (w_accept) begin
      r_ptr      <= w_grant0 ? c_ID_REQ1 : c_ID_REQ0;
      r_rom_addr <= w_addr;
    end
  end

  // Tag pipeline mirrors the ROM's address-register plus read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_id  <= c_ID_REQ0;
      r_s2_vld <= 1'b0;
      r_s2_id  <= c_ID_REQ0;
    end else begin
      r_s1_vld <= w_accept;
      r_s1_id  <= w_grant1 ? c_ID_REQ1 : c_ID_REQ0;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp0_vld  <= 1'b0;
      r_rsp1_vld  <= 1'b0;
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      r_rsp0_vld <= r_s2_vld & (r_s2_id == c_ID_REQ0);
      r_rsp1_vld <= r_s2_vld & (r_s2_id == c_ID_REQ1);
      if (r_s2_vld && (r_s2_id == c_ID_REQ0)) begin
        r_rsp0_data <= i_rom_data;
      end
      if (r_s2_vld && (r_s2_id == c_ID_REQ1)) begin
        r_rsp1_data <= i_rom_data;
      end
    end
  end

  assign req0.rsp_valid = r_rsp0_vld;
  assign req0.rsp_data  = r_rsp0_data;
  assign req1.rsp_valid = r_rsp1_vld;
  assign req1.rsp_data  = r_rsp1_data;
  assign o_rom_addr     = r_rom_addr;
  assign o_idle         = ~(r_s1_vld | r_s2_vld | r_rsp0_vld | r_rsp1_vld);

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rom_arbiter : directed vector bench for rom_arbiter           |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_rom_arbiter;

  typedef struct {
    logic       v0;
    logic [7:0] a0;
    logic       v1;
    logic [7:0] a1;
    logic       r0;
    logic       r1;
    logic       p0;
    logic [7:0] d0;
    logic       p1;
    logic [7:0] d1;
    logic       idle;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       idle;
  logic [7:0] mem [256];
  vec_t       tbl [31];
  int         n_tests;
  int         n_fail;

  rom_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) u_req0_if ();
  rom_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) u_req1_if ();

  rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .req0       (u_req0_if),
    .req1       (u_req1_if),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM model
  always_ff @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [7:0] a0, input logic v1,
                              input logic [7:0] a1, input logic r0, input logic r1,
                              input logic p0, input logic [7:0] d0, input logic p1,
                              input logic [7:0] d1, input logic id);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.r0 = r0; v.r1 = r1;
    v.p0 = p0; v.d0 = d0; v.p1 = p1; v.d1 = d1; v.idle = id;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [7:0] a0, input logic v1, input logic [7:0] a1);
    u_req0_if.valid = v0;
    u_req0_if.addr  = a0;
    u_req1_if.valid = v1;
    u_req1_if.addr  = a1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    //         v0 a0     v1 a1     r0 r1 p0 d0     p1 d1     idle
    // contention, both valid for 6 cycles
    tbl[0]  = mk(1, 8'h00, 1, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 1);
    tbl[1]  = mk(1, 8'h00, 1, 8'hFF, 0, 1, 0, 8'h00, 0, 8'h00, 0);
    tbl[2]  = mk(1, 8'h00, 1, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    tbl[3]  = mk(1, 8'h00, 1, 8'hFF, 0, 1, 1, 8'hA5, 0, 8'h00, 0);
    tbl[4]  = mk(1, 8'h00, 1, 8'hFF, 1, 0, 0, 8'h00, 1, 8'h5A, 0);
    tbl[5]  = mk(1, 8'h00, 1, 8'hFF, 0, 1, 1, 8'hA5, 0, 8'h00, 0);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h5A, 0);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'hA5, 0, 8'h00, 0);
    tbl[8]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h5A, 0);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1);
    // back-to-back on requester 1
    tbl[10] = mk(0, 8'h00, 1, 8'h01, 0, 1, 0, 8'h00, 0, 8'h00, 1);
    tbl[11] = mk(0, 8'h00, 1, 8'h02, 0, 1, 0, 8'h00, 0, 8'h00, 0);
    tbl[12] = mk(0, 8'h00, 1, 8'h03, 0, 1, 0, 8'h00, 0, 8'h00, 0);
    tbl[13] = mk(0, 8'h00, 1, 8'h04, 0, 1, 0, 8'h00, 1, 8'hA4, 0);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA7, 0);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA6, 0);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA1, 0);
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1);
    // single read on requester 0, then pointer hold over idle cycles
    tbl[18] = mk(1, 8'h03, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1);
    tbl[19] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    tbl[20] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    tbl[21] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'hA6, 0, 8'h00, 0);
    tbl[22] = mk(1, 8'h05, 1, 8'h06, 0, 1, 0, 8'h00, 0, 8'h00, 1);
    tbl[23] = mk(1, 8'h05, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0);
    // address change while blocked
    tbl[24] = mk(0, 8'h00, 1, 8'h30, 0, 1, 0, 8'h00, 0, 8'h00, 0);
    tbl[25] = mk(1, 8'h07, 1, 8'h20, 1, 0, 0, 8'h00, 1, 8'hA3, 0);
    tbl[26] = mk(0, 8'h00, 1, 8'h21, 0, 1, 1, 8'hA0, 0, 8'h00, 0);
    tbl[27] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h95, 0);
    tbl[28] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'hA2, 0, 8'h00, 0);
    tbl[29] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h84, 0);
    tbl[30] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1);

    rst_n = 1'b0;
    drive(0, 8'h00, 0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rom_addr",  32'(rom_addr), 32'h0);
    chk("reset_idle",      32'(idle), 32'h1);
    chk("reset_rsp0_vld",  32'(u_req0_if.rsp_valid), 32'h0);
    chk("reset_rsp1_vld",  32'(u_req1_if.rsp_valid), 32'h0);
    chk("reset_rsp0_data", 32'(u_req0_if.rsp_data), 32'h0);
    chk("reset_rsp1_data", 32'(u_req1_if.rsp_data), 32'h0);
    chk("reset_ready0",    32'(u_req0_if.ready), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1);
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(u_req0_if.ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d_ready1", i), 32'(u_req1_if.ready), 32'(tbl[i].r1));
      chk($sformatf("v%0d_rsp0_vld", i), 32'(u_req0_if.rsp_valid), 32'(tbl[i].p0));
      chk($sformatf("v%0d_rsp1_vld", i), 32'(u_req1_if.rsp_valid), 32'(tbl[i].p1));
      if (tbl[i].p0) chk($sformatf("v%0d_rsp0_data", i), 32'(u_req0_if.rsp_data), 32'(tbl[i].d0));
      if (tbl[i].p1) chk($sformatf("v%0d_rsp1_data", i), 32'(u_req1_if.rsp_data), 32'(tbl[i].d1));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tbl[i].idle));
    end

    // Data registers hold their last captured values between pulses
    chk("hold_rsp0_data", 32'(u_req0_if.rsp_data), 32'hA2);
    chk("hold_rsp1_data", 32'(u_req1_if.rsp_data), 32'h84);
    chk("hold_rom_addr",  32'(rom_addr), 32'h21);

    // Reset one cycle after accepting a read: the read must vanish
    @(negedge clk);
    drive(1, 8'h10, 0, 8'h00);
    #1;
    chk("mid_ready0", 32'(u_req0_if.ready), 32'h1);
    @(negedge clk);
    drive(0, 8'h00, 0, 8'h00);
    #1;
    chk("mid_rom_addr_pre", 32'(rom_addr), 32'h10);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rom_addr", 32'(rom_addr), 32'h0);
    chk("mid_idle",     32'(idle), 32'h1);
    chk("mid_rsp0_dat", 32'(u_req0_if.rsp_data), 32'h0);
    chk("mid_rsp1_dat", 32'(u_req1_if.rsp_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_rsp0_vld", i), 32'(u_req0_if.rsp_valid), 32'h0);
      chk($sformatf("post_rst%0d_rsp1_vld", i), 32'(u_req1_if.rsp_valid), 32'h0);
      chk($sformatf("post_rst%0d_idle", i),     32'(idle), 32'h1);
    end

    // Pointer back to requester 0 after reset
    @(negedge clk);
    drive(1, 8'h11, 1, 8'h12);
    #1;
    chk("post_rst_ptr_ready0", 32'(u_req0_if.ready), 32'h1);
    chk("post_rst_ptr_ready1", 32'(u_req1_if.ready), 32'h0);
    @(negedge clk);
    drive(0, 8'h00, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
